// File: rtl/flash_pkg.sv
// Shared types and constants for the SPI-flash-to-cache boot loader.
// Latency: none (definitions only).
// Backpressure: none (definitions only).
package flash_pkg;

   // Loader sequence; READ -> WRITE -> WRITE_WAIT -> READ repeats once per word.
   typedef enum logic [2:0] {
      POWER_WAIT,
      SEND_CMD,
      SEND_ADDR,
      READ,
      WRITE,
      WRITE_WAIT,
      DONE
   } state_e;

   // Standard SPI-flash "read data" opcode.
   localparam logic [7:0] CMD_READ = 8'h03;

endpackage

// File: rtl/flash_spi_byte.sv
// SPI mode-0 byte shifter: 8 bits out/in, MSB first, 2 clk cycles per bit (sclk low, then high).
// Latency: 16 cycles per byte; done_o is high in the last (sclk high) cycle so a new start_i chains with no gap.
// Backpressure: none; the caller only pulses start_i when idle or in the done_o cycle.
// Ports: clk/rst_n clock and async active-low reset; start_i/tx_byte_i begin a byte;
//        miso_i serial in; sclk_o/mosi_o serial out; done_o/rx_byte_o byte complete and received value.
module flash_spi_byte (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start_i,
   input  logic [7:0] tx_byte_i,
   input  logic       miso_i,
   output logic       sclk_o,
   output logic       mosi_o,
   output logic       done_o,
   output logic [7:0] rx_byte_o
);

   logic       active_q, active_d;
   logic       phase_q, phase_d;   // 0: sclk low half, 1: sclk high half
   logic [2:0] bit_q, bit_d;
   logic [7:0] tx_q, tx_d;
   logic [7:0] rx_q, rx_d;
   logic       sclk_q, sclk_d;
   logic       mosi_q, mosi_d;

   always_comb begin
      active_d = active_q;
      phase_d  = phase_q;
      bit_d    = bit_q;
      tx_d     = tx_q;
      rx_d     = rx_q;
      sclk_d   = sclk_q;
      mosi_d   = mosi_q;
      if (start_i) begin
         // First bit goes out immediately with sclk low.
         active_d = 1'b1;
         phase_d  = 1'b0;
         bit_d    = 3'd0;
         sclk_d   = 1'b0;
         mosi_d   = tx_byte_i[7];
         tx_d     = {tx_byte_i[6:0], 1'b0};
      end else if (active_q) begin
         if (!phase_q) begin
            // Rising sclk: capture what the flash drove during the low half.
            sclk_d  = 1'b1;
            rx_d    = {rx_q[6:0], miso_i};
            phase_d = 1'b1;
         end else begin
            sclk_d  = 1'b0;
            phase_d = 1'b0;
            if (bit_q == 3'd7) begin
               active_d = 1'b0;
               mosi_d   = 1'b0;
            end else begin
               mosi_d = tx_q[7];
               tx_d   = {tx_q[6:0], 1'b0};
               bit_d  = bit_q + 3'd1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         active_q <= 1'b0;
         phase_q  <= 1'b0;
         bit_q    <= 3'd0;
         tx_q     <= 8'h00;
         rx_q     <= 8'h00;
         sclk_q   <= 1'b0;
         mosi_q   <= 1'b0;
      end else begin
         active_q <= active_d;
         phase_q  <= phase_d;
         bit_q    <= bit_d;
         tx_q     <= tx_d;
         rx_q     <= rx_d;
         sclk_q   <= sclk_d;
         mosi_q   <= mosi_d;
      end
   end

   assign sclk_o    = sclk_q;
   assign mosi_o    = mosi_q;
   assign done_o    = active_q && phase_q && (bit_q == 3'd7);
   assign rx_byte_o = rx_q;

endmodule

// File: rtl/flash_loader.sv
// Boot loader: after a power-up wait, streams TRANSFER_BYTES from SPI flash and writes them as 32-bit words into a cache.
// Latency: STARTUP_WAIT+1 cycles to chip select, 64 cycles for command+address, 64 cycles per word plus cache wait.
// Backpressure: cache_busy stalls WRITE/WRITE_WAIT indefinitely with flash_clk parked low and all outputs stable.
// Ports: clk/rst_n clock and async active-low reset; flash_clk/flash_mosi/flash_miso/flash_cs SPI mode-0 master;
//        cache_address/cache_data_in/cache_write_enable/cache_busy word write port; done sticky completion flag.
module flash_loader
   import flash_pkg::*;
#(
   parameter int unsigned STARTUP_WAIT   = 1_000_000,
   parameter logic [31:0] TRANSFER_BYTES = 32'h0010_0000,
   parameter logic [23:0] FLASH_ADDRESS  = 24'h00_0000,
   parameter logic [31:0] DEST_ADDRESS   = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        flash_clk,
   output logic        flash_mosi,
   input  logic        flash_miso,
   output logic        flash_cs,
   output logic [31:0] cache_address,
   output logic [31:0] cache_data_in,
   output logic [3:0]  cache_write_enable,
   input  logic        cache_busy,
   output logic        done
);

   localparam logic [31:0] WAIT_LAST = 32'(STARTUP_WAIT);
   localparam bit          EMPTY     = (TRANSFER_BYTES == 32'd0);
   localparam logic [31:0] LAST_WORD = (TRANSFER_BYTES >> 2) - 32'd1;

   state_e      state_q, state_d;
   logic [31:0] wait_q, wait_d;
   logic [1:0]  byte_q, byte_d;
   logic [31:0] word_q, word_d;    // index of the word currently being read/written
   logic [31:0] shift_q, shift_d;  // word under assembly, bytes enter at the top
   logic        cs_q, cs_d;
   logic        done_q, done_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] data_q, data_d;

   logic        spi_start;
   logic [7:0]  spi_tx;
   logic        spi_done;
   logic [7:0]  spi_rx;
   logic [3:0]  we;

   flash_spi_byte u_spi (
      .clk       (clk),
      .rst_n     (rst_n),
      .start_i   (spi_start),
      .tx_byte_i (spi_tx),
      .miso_i    (flash_miso),
      .sclk_o    (flash_clk),
      .mosi_o    (flash_mosi),
      .done_o    (spi_done),
      .rx_byte_o (spi_rx)
   );

   always_comb begin
      state_d   = state_q;
      wait_d    = wait_q;
      byte_d    = byte_q;
      word_d    = word_q;
      shift_d   = shift_q;
      cs_d      = cs_q;
      done_d    = done_q;
      addr_d    = addr_q;
      data_d    = data_q;
      spi_start = 1'b0;
      spi_tx    = 8'h00;
      we        = 4'h0;
      case (state_q)
         POWER_WAIT: begin
            if (wait_q == WAIT_LAST) begin
               if (EMPTY) begin
                  state_d = DONE;
                  done_d  = 1'b1;
               end else begin
                  state_d   = SEND_CMD;
                  cs_d      = 1'b0;
                  spi_start = 1'b1;
                  spi_tx    = CMD_READ;
               end
            end else begin
               wait_d = wait_q + 32'd1;
            end
         end
         SEND_CMD: begin
            if (spi_done) begin
               state_d   = SEND_ADDR;
               byte_d    = 2'd0;
               spi_start = 1'b1;
               spi_tx    = FLASH_ADDRESS[23:16];
            end
         end
         SEND_ADDR: begin
            // byte_q counts address bytes already sent after the top one.
            if (spi_done) begin
               spi_start = 1'b1;
               if (byte_q == 2'd2) begin
                  state_d = READ;
                  byte_d  = 2'd0;
               end else begin
                  byte_d = byte_q + 2'd1;
                  spi_tx = (byte_q == 2'd0) ? FLASH_ADDRESS[15:8] : FLASH_ADDRESS[7:0];
               end
            end
         end
         READ: begin
            // Shifting in from the top leaves the first byte in [7:0] (little-endian).
            if (spi_done) begin
               shift_d = {spi_rx, shift_q[31:8]};
               if (byte_q == 2'd3) begin
                  state_d = WRITE;
                  byte_d  = 2'd0;
                  addr_d  = DEST_ADDRESS + {word_q[29:0], 2'b00};
                  data_d  = {spi_rx, shift_q[31:8]};
               end else begin
                  byte_d    = byte_q + 2'd1;
                  spi_start = 1'b1;
               end
            end
         end
         WRITE: begin
            if (!cache_busy) begin
               we      = 4'hF;
               state_d = WRITE_WAIT;
            end
         end
         WRITE_WAIT: begin
            if (!cache_busy) begin
               if (word_q == LAST_WORD) begin
                  state_d = DONE;
                  cs_d    = 1'b1;
                  done_d  = 1'b1;
               end else begin
                  // Flash is still selected mid-stream; just resume clocking.
                  word_d    = word_q + 32'd1;
                  state_d   = READ;
                  spi_start = 1'b1;
               end
            end
         end
         DONE: begin
         end
         default: state_d = POWER_WAIT;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= POWER_WAIT;
         wait_q  <= 32'd0;
         byte_q  <= 2'd0;
         word_q  <= 32'd0;
         shift_q <= 32'd0;
         cs_q    <= 1'b1;
         done_q  <= 1'b0;
         addr_q  <= 32'd0;
         data_q  <= 32'd0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
         byte_q  <= byte_d;
         word_q  <= word_d;
         shift_q <= shift_d;
         cs_q    <= cs_d;
         done_q  <= done_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
      end
   end

   assign flash_cs           = cs_q;
   assign done               = done_q;
   assign cache_address      = addr_q;
   assign cache_data_in      = data_q;
   assign cache_write_enable = we;

endmodule

// File: tb/tb_flash_loader.sv
module tb_flash_loader;

   localparam int          SW = 10;
   localparam logic [31:0] NB = 32'd16;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n, rst_z_n;

   // Main instance: 16 bytes from flash 0 to cache 0
   logic a_clk, a_mosi, a_miso, a_cs, a_busy, a_done;
   logic [31:0] a_addr, a_data;
   logic [3:0]  a_we;
   // Zero-length instance
   logic z_clk, z_mosi, z_cs, z_done;
   logic [31:0] z_addr, z_data;
   logic [3:0]  z_we;
   // Wrap-around instance: miso tied high, destination near the top of the address space
   logic w_clk, w_mosi, w_cs, w_done;
   logic [31:0] w_addr, w_data;
   logic [3:0]  w_we;

   flash_loader #(.STARTUP_WAIT(SW), .TRANSFER_BYTES(NB), .FLASH_ADDRESS(24'h0), .DEST_ADDRESS(32'h0)) dut_a (
      .clk(clk), .rst_n(rst_n), .flash_clk(a_clk), .flash_mosi(a_mosi), .flash_miso(a_miso),
      .flash_cs(a_cs), .cache_address(a_addr), .cache_data_in(a_data), .cache_write_enable(a_we),
      .cache_busy(a_busy), .done(a_done));

   flash_loader #(.STARTUP_WAIT(SW), .TRANSFER_BYTES(32'd0), .FLASH_ADDRESS(24'h0), .DEST_ADDRESS(32'h0)) dut_z (
      .clk(clk), .rst_n(rst_z_n), .flash_clk(z_clk), .flash_mosi(z_mosi), .flash_miso(1'b0),
      .flash_cs(z_cs), .cache_address(z_addr), .cache_data_in(z_data), .cache_write_enable(z_we),
      .cache_busy(1'b0), .done(z_done));

   flash_loader #(.STARTUP_WAIT(SW), .TRANSFER_BYTES(32'd8), .FLASH_ADDRESS(24'h0), .DEST_ADDRESS(32'hFFFF_FFFC)) dut_w (
      .clk(clk), .rst_n(rst_z_n), .flash_clk(w_clk), .flash_mosi(w_mosi), .flash_miso(1'b1),
      .flash_cs(w_cs), .cache_address(w_addr), .cache_data_in(w_data), .cache_write_enable(w_we),
      .cache_busy(1'b0), .done(w_done));

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // ---------------- Behavioural SPI flash for dut_a ----------------
   logic [7:0]  mem [0:255];
   int unsigned fbits = 0;
   logic [31:0] fcmd;
   int unsigned words_streamed = 0;
   int unsigned words_stalled  = 0;
   int          mosi_read_err  = 0;

   always @(negedge a_cs) begin
      fbits          = 0;
      words_streamed = 0;
      words_stalled  = 0;
   end

   always @(posedge a_clk) begin
      if (a_cs === 1'b0) begin
         if (fbits < 32) fcmd = {fcmd[30:0], a_mosi};
         else if (a_mosi !== 1'b0) mosi_read_err++;
         fbits++;
         if (fbits == 32) check("flash_cmd_addr", {32'h0, fcmd}, {32'h0, 8'h03, 24'h000000});
         if (fbits > 32 && ((fbits - 32) % 32) == 0) words_streamed++;
      end
   end

   // Mode 0: flash shifts the next data bit out on the falling clock.
   always @(negedge a_clk) begin
      if (a_cs === 1'b0 && fbits >= 32)
         a_miso = mem[((fbits - 32) / 8) % 256][7 - ((fbits - 32) % 8)];
   end

   // ---------------- cache_busy driver ----------------
   bit          stall_mode = 1'b1;
   int          stalls_done = 0;
   logic [31:0] st_addr, st_data;

   always begin
      @(posedge clk);
      #1;
      if (stall_mode && rst_n === 1'b1) begin
         if (words_streamed > words_stalled) begin
            int clk_hi;
            words_stalled = words_streamed;
            a_busy = 1'b1;
            clk_hi = 0;
            for (int i = 1; i <= 20; i++) begin
               @(negedge clk);
               if (i >= 2 && a_clk !== 1'b0) clk_hi++;
               if (i == 2) begin st_addr = a_addr; st_data = a_data; end
            end
            check("stall_flash_clk_low", 64'(clk_hi), 64'd0);
            check("stall_outputs_stable", {a_addr, a_data}, {st_addr, st_data});
            @(posedge clk);
            #1;
            a_busy = 1'b0;
            stalls_done++;
         end else begin
            a_busy = 1'b0;
         end
      end else begin
         a_busy = ($urandom_range(0, 3) == 0);
      end
   end

   // ---------------- Scoreboards / monitors ----------------
   typedef struct packed { logic [31:0] addr; logic [31:0] data; } wr_t;
   wr_t  exp_q[$];
   wr_t  w_q[$];
   wr_t  e;
   wr_t  we_e;
   logic [3:0] we_prev = 4'h0;
   int   writes_seen = 0;
   bit   z_cs_low_seen = 0, z_write_seen = 0;

   // Reference: word n = flash bytes FA+4n..FA+4n+3, first byte least significant, at DEST+4n.
   task automatic push_expected();
      wr_t t;
      for (int n = 0; n < int'(NB / 4); n++) begin
         t.addr = 32'h0 + 32'(4 * n);
         t.data = {mem[4*n+3], mem[4*n+2], mem[4*n+1], mem[4*n]};
         exp_q.push_back(t);
      end
   endtask

   always @(negedge clk) begin
      if (a_we !== 4'h0) begin
         writes_seen++;
         check("strobe_value", 64'(a_we), 64'hF);
         check("strobe_single_cycle", 64'(we_prev), 64'h0);
         check("no_write_in_reset", 64'(rst_n), 64'h1);
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write actual=%0h required=none", a_addr);
         end else begin
            e = exp_q.pop_front();
            check("write_addr", 64'(a_addr), 64'(e.addr));
            check("write_data", 64'(a_data), 64'(e.data));
         end
      end
      we_prev = a_we;

      if (rst_z_n === 1'b1 && z_cs === 1'b0) z_cs_low_seen = 1;
      if (z_we !== 4'h0) z_write_seen = 1;

      if (w_we !== 4'h0) begin
         if (w_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL w_unexpected_write actual=%0h required=none", w_addr);
         end else begin
            we_e = w_q.pop_front();
            check("w_write_addr", 64'(w_addr), 64'(we_e.addr));
            check("w_write_data", 64'(w_data), 64'(we_e.data));
         end
      end
   end

   task automatic wait_done(input string name);
      int n = 0;
      while (a_done !== 1'b1 && n < 5000) begin
         @(posedge clk);
         n++;
      end
      #1;
      check(name, 64'(a_done), 64'h1);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_cs"},   64'(a_cs),   64'h1);
      check({tag, "_sclk"}, 64'(a_clk),  64'h0);
      check({tag, "_mosi"}, 64'(a_mosi), 64'h0);
      check({tag, "_we"},   64'(a_we),   64'h0);
      check({tag, "_addr"}, 64'(a_addr), 64'h0);
      check({tag, "_data"}, 64'(a_data), 64'h0);
      check({tag, "_done"}, 64'(a_done), 64'h0);
   endtask

   // ---------------- Main sequence ----------------
   initial begin
      int cs_cycles;
      int n;
      rst_n = 1'b1;
      rst_z_n = 1'b1;
      a_busy = 1'b0;
      a_miso = 1'b0;
      mem[0] = 8'h0a; mem[1] = 8'h61; mem[2] = 8'h62; mem[3] = 8'h63;
      for (int i = 4; i < 256; i++) mem[i] = 8'($urandom);
      #2;
      rst_n = 1'b0;
      rst_z_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("reset");

      push_expected();
      w_q.push_back('{addr: 32'hFFFF_FFFC, data: 32'hFFFF_FFFF});
      w_q.push_back('{addr: 32'h0000_0000, data: 32'hFFFF_FFFF});

      // Run 1: every write stalled for 20 cycles
      @(negedge clk);
      rst_n = 1'b1;
      rst_z_n = 1'b1;
      cs_cycles = 0;
      while (a_cs === 1'b1 && cs_cycles < 100) begin
         @(posedge clk);
         #1;
         cs_cycles++;
         if (cs_cycles == 10) check("z_done_not_early", 64'(z_done), 64'h0);
      end
      check("cs_high_cycles", 64'(cs_cycles), 64'd11);
      check("z_done_after_wait", 64'(z_done), 64'h1);

      wait_done("run1_done");
      check("run1_writes", 64'(writes_seen), 64'd4);
      check("run1_queue_empty", 64'(exp_q.size()), 64'd0);
      check("run1_stalls", 64'(stalls_done), 64'd4);
      check("done_cs_high", 64'(a_cs), 64'h1);
      check("done_sclk_low", 64'(a_clk), 64'h0);
      check("mosi_zero_in_read", 64'(mosi_read_err), 64'd0);
      check("z_done_held", 64'(z_done), 64'h1);
      check("z_no_cs", 64'(z_cs_low_seen), 64'h0);
      check("z_no_write", 64'(z_write_seen), 64'h0);
      check("w_done", 64'(w_done), 64'h1);
      check("w_queue_empty", 64'(w_q.size()), 64'd0);

      // Run 2: random busy, reset pulse after the 2nd write
      @(negedge clk);
      stall_mode = 1'b0;
      rst_n = 1'b0;
      exp_q.delete();
      push_expected();
      writes_seen = 0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      n = 0;
      while (writes_seen < 2 && n < 5000) begin
         @(posedge clk);
         n++;
      end
      check("run2_two_writes", 64'(writes_seen), 64'd2);
      repeat ($urandom_range(5, 40)) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check_reset_outputs("midreset");
      repeat (5) @(negedge clk);
      exp_q.delete();
      push_expected();
      writes_seen = 0;
      rst_n = 1'b1;
      wait_done("run2_done");
      check("run2_writes", 64'(writes_seen), 64'd4);
      check("run2_queue_empty", 64'(exp_q.size()), 64'd0);
      check("run2_mosi_zero_in_read", 64'(mosi_read_err), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/flash_loader.md
FLASH_LOADER -- requirements
Module: flash_loader

Interface
REQ-001 SHALL have parameter STARTUP_WAIT, default 1_000_000, clk cycles to wait after reset before the first flash access.
REQ-002 SHALL have parameter TRANSFER_BYTES, default 32'h0010_0000, bytes copied; must be a multiple of 4.
REQ-003 SHALL have parameter FLASH_ADDRESS, default 24'h00_0000, first flash byte address.
REQ-004 SHALL have parameter DEST_ADDRESS, default 32'h0000_0000, first cache byte address.
REQ-005 SHALL have port clk  in  1  single clock for all logic.
REQ-006 SHALL have port rst_n  in  1  reset, asynchronous assert, active-low.
REQ-007 SHALL have port flash_clk  out  1  SPI clock (mode 0).
REQ-008 SHALL have port flash_mosi  out  1  SPI data to flash.
REQ-009 SHALL have port flash_miso  in  1  SPI data from flash.
REQ-010 SHALL have port flash_cs  out  1  SPI chip select, active-low.
REQ-011 SHALL have port cache_address  out  32  byte address of the word being written.
REQ-012 SHALL have port cache_data_in  out  32  word to write.
REQ-013 SHALL have port cache_write_enable  out  4  byte-lane write strobe.
REQ-014 SHALL have port cache_busy  in  1  cache cannot accept a request.
REQ-015 SHALL have port done  out  1  copy complete, held until reset.

Function
REQ-016 SHALL use states POWER_WAIT, SEND_CMD, SEND_ADDR, READ, WRITE, WRITE_WAIT, DONE, entered in that order; READ->WRITE->WRITE_WAIT->READ repeats per word.
REQ-017 POWER_WAIT SHALL count to STARTUP_WAIT, then drive flash_cs low and go to SEND_CMD.
REQ-018 SEND_CMD SHALL shift 8'h03 MSB-first; SEND_ADDR SHALL shift FLASH_ADDRESS (24 bits) MSB-first.
REQ-019 Each SPI bit SHALL take 2 clk cycles: flash_clk low with flash_mosi updated, then flash_clk high; flash_miso sampled on the low-to-high cycle.
REQ-020 READ SHALL collect 4 bytes MSB-first per byte, packing them little-endian (first byte -> [7:0]); flash_mosi SHALL be 0 during READ.
REQ-021 WRITE SHALL wait for cache_busy==0, then drive cache_address, cache_data_in and cache_write_enable=4'b1111 for exactly one cycle.
REQ-022 WRITE_WAIT SHALL hold cache_write_enable=0 and return to READ, or to DONE after the last word, once cache_busy==0.
REQ-023 flash_clk SHALL be held low and flash_cs held low through WRITE/WRITE_WAIT; the flash stream resumes without a new command.
REQ-024 cache_address SHALL be DEST_ADDRESS+4*n for word n, in 32-bit wrap-around arithmetic.
REQ-025 Entering DONE SHALL drive flash_cs high, flash_clk low and done=1; DONE is terminal.
REQ-026 TRANSFER_BYTES==0 SHALL go POWER_WAIT->DONE with flash_cs never asserted and no cache write.
REQ-027 cache_busy held high SHALL stall WRITE indefinitely with all outputs stable.

Reset
REQ-028 rst_n low SHALL immediately force flash_cs=1, flash_clk=0, flash_mosi=0, cache_write_enable=0, cache_address=0, cache_data_in=0, done=0, all counters 0, state POWER_WAIT.
REQ-029 Reset mid-transfer SHALL abort with no further cache write; after release the copy restarts from POWER_WAIT.

Structure
REQ-030 Package flash_pkg SHALL hold the state enum and the read command constant 8'h03.
REQ-031 One sub-module, flash_spi_byte, SHALL implement the 2-cycle-per-bit 8-bit shift in/out; all sequencing stays in flash_loader.

Verification
REQ-032 STARTUP_WAIT=10: flash_cs stays high for 11 cycles after reset release, then the first 32 flash_clk rises carry 0x03 followed by 0x000000.
REQ-033 Flash model bytes 0x0a,0x61,0x62,0x63 at address 0: first write is address 0x0, data 0x6362610a, strobe 4'b1111 for exactly 1 cycle.
REQ-034 TRANSFER_BYTES=16, cache_busy held high 20 cycles per write: exactly 4 writes to addresses 0,4,8,12; flash_clk low during each stall; done=1 afterwards.
REQ-035 TRANSFER_BYTES=0: done=1 after POWER_WAIT, with no flash_cs low and no write.
REQ-036 rst_n pulsed low after the 2nd write: outputs reset immediately, no write strobes while rst_n is low; after release the sequence restarts and the first write is again to DEST_ADDRESS.
